clock_period_meter: RTL and testbench

//  Measures the period of a slow, asynchronous divided clock (clk_meas) in clk_in cycles and

---
 rtl/clk_meter_pkg.sv | 22 ++
 rtl/sync_edge_detect.sv | 35 +++
 rtl/clock_period_meter.sv | 159 +++++++++++++++
 tb/tb_clock_period_meter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_meter_pkg.sv
// +------------------------------------------------------------------+
// | Module  : clk_meter_pkg                                          |
// | Brief   : Shared FSM state type and default sizing for the meter |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package clk_meter_pkg;

   localparam int                 C_CNT_W   = 33;
   localparam logic [C_CNT_W-1:0] C_TIMEOUT = 33'h10000;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_MEASURE = 2'd2,
      ST_LOST    = 2'd3
   } meter_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge_detect.sv
// +------------------------------------------------------------------+
// | Module  : sync_edge_detect                                       |
// | Brief   : 2-flop synchronizer plus history flop, rising pulse    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module sync_edge_detect (
   input  logic clk_in,
   input  logic reset,
   input  logic sig_in,
   output logic rise
);

   logic r_s1;
   logic r_s2;
   logic r_s3;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= sig_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign rise = r_s2 & ~r_s3;

endmodule

`default_nettype wire

// File: rtl/clock_period_meter.sv
// +------------------------------------------------------------------+
// | Module  : clock_period_meter                                     |
// | Brief   : Measures clk_meas period in clk_in cycles, recovers    |
// |           the divide value, reports lock and clock loss.         |
// |           Optional macro STABLE_CHECK_EN: lock needs two equal   |
// |           consecutive measurements.                              |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module clock_period_meter
   import clk_meter_pkg::*;
#(
   parameter int               CNT_W   = C_CNT_W,
   parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(C_TIMEOUT)
) (
   input  logic             clk_in,
   input  logic             reset,
   input  logic             clk_meas,
   input  logic             enable,
   output logic [CNT_W-1:0] period_out,
   output logic [CNT_W-1:0] div_est,
   output logic             meas_valid,
   output logic             locked,
   output logic             timeout
);

   meter_state_t     r_state;
   meter_state_t     w_state_nxt;
   logic             w_edge;
   logic             w_measure;
   logic             w_lose;
   logic             w_restart;
   logic [CNT_W-1:0] w_div;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_div;
   logic             r_valid;
   logic             r_locked;
   logic             r_timeout;

   sync_edge_detect u_sync (
      .clk_in (clk_in),
      .reset  (reset),
      .sig_in (clk_meas),
      .rise   (w_edge)
   );

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // enable=0 overrides every event; an edge wins over a coincident timeout
   always_comb begin
      w_state_nxt = r_state;
      w_measure   = 1'b0;
      w_lose      = 1'b0;
      w_restart   = 1'b0;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nxt = ST_ARMED;
            ST_ARMED: begin
               if (w_edge) begin
                  w_state_nxt = ST_MEASURE;
                  w_restart   = 1'b1;
               end
            end
            ST_MEASURE: begin
               if (w_edge) begin
                  w_measure = 1'b1;
                  w_restart = 1'b1;
               end else if (r_cnt == TIMEOUT) begin
                  w_state_nxt = ST_LOST;
                  w_lose      = 1'b1;
               end
            end
            ST_LOST: begin
               if (w_edge) begin
                  w_state_nxt = ST_MEASURE;
                  w_restart   = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_div = (r_cnt < CNT_W'(2)) ? '0 : (r_cnt >> 1) - CNT_W'(1);

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (!enable) begin
         r_cnt <= '0;
      end else if (w_restart) begin
         r_cnt <= CNT_W'(1);
      end else if (r_state == ST_MEASURE && !w_lose) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_period  <= '0;
         r_div     <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_valid <= w_measure;
         if (w_measure) begin
            r_period <= r_cnt;
            r_div    <= w_div;
         end
         if (!enable)                               r_timeout <= 1'b0;
         else if (w_lose)                           r_timeout <= 1'b1;
         else if (r_state == ST_LOST && w_edge)     r_timeout <= 1'b0;
      end
   end

`ifdef STABLE_CHECK_EN
   // A zero prev_period never matches a real measurement, so clearing it invalidates it
   logic [CNT_W-1:0] r_prev_period;

   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_prev_period <= '0;
         r_locked      <= 1'b0;
      end else if (!enable || w_lose) begin
         r_prev_period <= '0;
         r_locked      <= 1'b0;
      end else if (w_measure) begin
         r_prev_period <= r_cnt;
         r_locked      <= (r_cnt == r_prev_period);
      end
   end
`else
   always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         r_locked <= 1'b0;
      end else if (!enable || w_lose) begin
         r_locked <= 1'b0;
      end else if (w_measure) begin
         r_locked <= 1'b1;
      end
   end
`endif

   assign period_out = r_period;
   assign div_est    = r_div;
   assign meas_valid = r_valid;
   assign locked     = r_locked;
   assign timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_clock_period_meter.sv
// +------------------------------------------------------------------+
// | Module  : tb_clock_period_meter                                  |
// | Brief   : Timestamp-based reference model and directed stimulus  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_clock_period_meter;

   localparam int          CNT_W = 33;
   localparam logic [63:0] TMO   = 64'd2500;

   localparam logic [1:0] M_IDLE  = 2'd0;
   localparam logic [1:0] M_ARMED = 2'd1;
   localparam logic [1:0] M_MEAS  = 2'd2;
   localparam logic [1:0] M_LOST  = 2'd3;

   logic             clk_in   = 1'b0;
   logic             reset    = 1'b0;
   logic             clk_meas = 1'b0;
   logic             enable   = 1'b0;
   logic [CNT_W-1:0] period_out;
   logic [CNT_W-1:0] div_est;
   logic             meas_valid;
   logic             locked;
   logic             timeout;

   int n_cmp = 0;
   int n_err = 0;
   int hi    = 5;
   int lo    = 5;
   bit run   = 1'b0;

   clock_period_meter #(
      .CNT_W   (CNT_W),
      .TIMEOUT (CNT_W'(TMO))
   ) dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .clk_meas   (clk_meas),
      .enable     (enable),
      .period_out (period_out),
      .div_est    (div_est),
      .meas_valid (meas_valid),
      .locked     (locked),
      .timeout    (timeout)
   );

   always #5 clk_in = ~clk_in;

   // Measured clock: hi cycles high, lo cycles low, edges aligned to clk_in negedge
   initial begin
      forever begin
         if (run) begin
            clk_meas = 1'b1;
            repeat (hi) @(negedge clk_in);
            clk_meas = 1'b0;
            repeat (lo) @(negedge clk_in);
         end else begin
            clk_meas = 1'b0;
            @(negedge clk_in);
         end
      end
   end

   // Reference model: period = cycles between detected rising edges
   typedef struct packed {
      logic [1:0]  mode;
      logic [63:0] last;
      logic [63:0] period;
      logic [63:0] div;
      logic [63:0] prev;
      logic        valid;
      logic        locked;
      logic        tmo;
   } mdl_t;

   function automatic mdl_t step(input mdl_t c, input logic det, input logic en,
                                 input logic [63:0] cyc);
      mdl_t        n;
      logic [63:0] p;
      n       = c;
      n.valid = 1'b0;
      if (!en) begin
         n.mode   = M_IDLE;
         n.locked = 1'b0;
         n.tmo    = 1'b0;
         n.prev   = '0;
      end else begin
         case (c.mode)
            M_IDLE: n.mode = M_ARMED;
            M_ARMED: if (det) begin n.last = cyc; n.mode = M_MEAS; end
            M_MEAS: begin
               if (det) begin
                  p        = cyc - c.last;
                  n.period = p;
                  n.div    = (p < 64'd2) ? 64'd0 : (p / 64'd2) - 64'd1;
                  n.valid  = 1'b1;
`ifdef STABLE_CHECK_EN
                  n.locked = (p == c.prev);
                  n.prev   = p;
`else
                  n.locked = 1'b1;
`endif
                  n.last   = cyc;
               end else if (cyc - c.last == TMO) begin
                  n.mode   = M_LOST;
                  n.tmo    = 1'b1;
                  n.locked = 1'b0;
                  n.prev   = '0;
               end
            end
            default: if (det) begin n.last = cyc; n.tmo = 1'b0; n.mode = M_MEAS; end
         endcase
      end
      return n;
   endfunction

   mdl_t        m;
   logic [2:0]  sh;
   logic [63:0] cyc;

   always @(posedge clk_in or negedge reset) begin
      if (!reset) begin
         m   <= '0;
         sh  <= '0;
         cyc <= '0;
      end else begin
         m   <= step(m, sh[1] & ~sh[2], enable, cyc);
         sh  <= {sh[1:0], clk_meas};
         cyc <= cyc + 64'd1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk_in) begin
      chk("model period_out", 64'(period_out), m.period);
      chk("model div_est",    64'(div_est),    m.div);
      chk("model meas_valid", 64'(meas_valid), 64'(m.valid));
      chk("model locked",     64'(locked),     64'(m.locked));
      chk("model timeout",    64'(timeout),    64'(m.tmo));
   end

   task automatic wait_valid(input int maxc, input string nm);
      int k;
      k = 0;
      @(negedge clk_in);
      while (meas_valid !== 1'b1 && k < maxc) begin
         @(negedge clk_in);
         k++;
      end
      chk({nm, " valid arrives"}, 64'(meas_valid), 64'd1);
   endtask

   task automatic wait_tmo(input logic want, input int maxc, input string nm);
      int k;
      k = 0;
      while (timeout !== want && k < maxc) begin
         @(negedge clk_in);
         k++;
      end
      chk({nm, " timeout level"}, 64'(timeout), 64'(want));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " period_out"}, 64'(period_out), 64'd0);
      chk({nm, " div_est"},    64'(div_est),    64'd0);
      chk({nm, " meas_valid"}, 64'(meas_valid), 64'd0);
      chk({nm, " locked"},     64'(locked),     64'd0);
      chk({nm, " timeout"},    64'(timeout),    64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk_in);
      #1 chk_zero("reset");
      @(negedge clk_in);
      reset = 1'b1;
      enable = 1'b1;
      hi = 5; lo = 5; run = 1'b1;

      wait_valid(100, "p10 first");
      chk("p10 period", 64'(period_out), 64'd10);
      chk("p10 div",    64'(div_est),    64'd4);
`ifdef STABLE_CHECK_EN
      chk("p10 first locked", 64'(locked), 64'd0);
`else
      chk("p10 first locked", 64'(locked), 64'd1);
`endif
      wait_valid(100, "p10 second");
      chk("p10b period", 64'(period_out), 64'd10);
      chk("p10b locked", 64'(locked),     64'd1);

      hi = 2; lo = 2;
      repeat (3) wait_valid(100, "p4");
      chk("p4 period", 64'(period_out), 64'd4);
      chk("p4 div",    64'(div_est),    64'd1);

      hi = 1001; lo = 1001;
      repeat (3) wait_valid(5000, "p2002");
      chk("p2002 period", 64'(period_out), 64'd2002);
      chk("p2002 div",    64'(div_est),    64'd1000);

      run = 1'b0;
      wait_tmo(1'b1, 6000, "loss");
      chk("loss locked", 64'(locked), 64'd0);

      hi = 5; lo = 5; run = 1'b1;
      wait_tmo(1'b0, 100, "restart");
      chk("restart no valid", 64'(meas_valid), 64'd0);
      wait_valid(100, "restart");
      chk("restart period", 64'(period_out), 64'd10);

      hi = 6; lo = 6;
      repeat (3) wait_valid(100, "p12");
      chk("p12 period", 64'(period_out), 64'd12);
      chk("p12 div",    64'(div_est),    64'd5);
      chk("p12 locked", 64'(locked),     64'd1);

      repeat (4) @(negedge clk_in);
      enable = 1'b0;
      @(negedge clk_in);
      chk("disable holds period", 64'(period_out), 64'd12);
      chk("disable locked",       64'(locked),     64'd0);
      repeat (5) @(negedge clk_in);
      enable = 1'b1;
      wait_valid(100, "re-enable");
      chk("re-enable period", 64'(period_out), 64'd12);

      repeat (7) @(negedge clk_in);
      #3 reset = 1'b0;
      #1 chk_zero("async reset");
      @(negedge clk_in);
      reset = 1'b1;
      wait_valid(100, "post reset");
      chk("post reset period", 64'(period_out), 64'd12);

      repeat (5) @(negedge clk_in);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
